// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
//
// Contents:
//   PC_STEP           byte increment between consecutive instruction words
//   DEFAULT_RESET_PC  PC loaded on reset unless overridden by the top parameter
//   fetch_entry_t     {pc, instr} pair carried by the fetch queue
//   fetch_state_t     fetch control states
package fetch_pkg;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO of fetch entries between ROM and decode
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   push         write push_data at the tail (ignored when full unless popping)
//   push_data    entry to write
//   pop          remove the head entry (ignored when empty)
//   flush        discard all entries; wins over push and pop
//   full, empty  occupancy flags
//   head         entry at the head; holds stale contents while empty
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A full queue can still accept a word when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RISC-V instruction fetch front end: PC, ROM read side, fetch queue, redirect
//
// Ports:
//   clk, reset                clock, asynchronous active-high reset
//   go                        leave IDLE and start fetching
//   stall                     suppress ROM reads this cycle (queue still drains)
//   branch, branch_address    redirect request and target
//   mem_en, mem_addr          ROM read enable and byte address (mem_addr is the PC)
//   mem_instr                 combinational ROM read data for mem_addr
//   out_valid, out_ready      decode handshake
//   out_instr, out_pc         head entry of the fetch queue
//   misalign                  one-cycle pulse after a branch whose target had bits [1:0] set
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] branch_address,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         misalign_q, misalign_d;

    logic         q_full;
    logic         q_empty;
    logic         pop;
    logic         fetch;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign pop        = !q_empty && out_ready;
    // Branch suppresses the read: the word at the old PC is on the wrong path.
    assign fetch      = (state_q == RUN) && !stall && !branch && (!q_full || pop);
    assign push_entry = '{pc: pc_q, instr: mem_instr};

    assign mem_en    = fetch;
    assign mem_addr  = pc_q;
    assign out_valid = !q_empty;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign misalign  = misalign_q;

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (fetch),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (branch),
        .full      (q_full),
        .empty     (q_empty),
        .head      (head)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (state_q == IDLE && go) begin
            state_d = RUN;
        end
        if (branch) begin
            pc_d       = {branch_address[31:2], 2'b00};
            misalign_d = |branch_address[1:0];
        end else if (fetch) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam int          QD      = 2;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0, stall = 1'b0, branch = 1'b0, ready = 1'b0;
    logic [31:0] ba = '0;
    logic        mem_en, out_valid, misalign;
    logic [31:0] mem_addr, mem_instr, out_instr, out_pc;

    logic        w_go = 1'b0, w_stall = 1'b0, w_branch = 1'b0, w_ready = 1'b1;
    logic [31:0] w_ba = '0;
    logic        w_en, w_valid, w_mis;
    logic [31:0] w_addr, w_instr, w_opc, w_oinstr;

    logic [31:0] rom [1024];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a running flag, a PC and a bounded list of fetched pairs.
    bit          m_run;
    logic [31:0] m_pc;
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    bit          m_mis;

    typedef struct {
        logic        g, s, b;
        logic [31:0] a;
        logic        r;
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic        e_mis;
    } row_t;
    row_t rows[$];

    always #5 clk = ~clk;

    assign mem_instr = rom[mem_addr[11:2]];
    assign w_instr   = rom[w_addr[11:2]];

    fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .reset(reset), .go(go), .stall(stall), .branch(branch),
        .branch_address(ba), .mem_en(mem_en), .mem_addr(mem_addr), .mem_instr(mem_instr),
        .out_valid(out_valid), .out_ready(ready), .out_instr(out_instr), .out_pc(out_pc),
        .misalign(misalign)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .QUEUE_DEPTH(QD)) dut_wrap (
        .clk(clk), .reset(reset), .go(w_go), .stall(w_stall), .branch(w_branch),
        .branch_address(w_ba), .mem_en(w_en), .mem_addr(w_addr), .mem_instr(w_instr),
        .out_valid(w_valid), .out_ready(w_ready), .out_instr(w_oinstr), .out_pc(w_opc),
        .misalign(w_mis)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pc  = 32'h0;
        m_mis = 1'b0;
        q_pc.delete();
        q_ins.delete();
    endtask

    function automatic bit model_fetch();
        bit pop_now;
        pop_now = (q_pc.size() != 0) && ready;
        return m_run && !stall && !branch && ((q_pc.size() < QD) || pop_now);
    endfunction

    // Drive inputs just after an edge, then compare against the model at the falling edge.
    task automatic apply(input logic g, s, b, input logic [31:0] a, input logic r);
        bit f;
        go = g; stall = s; branch = b; ba = a; ready = r;
        @(negedge clk);
        f = model_fetch();
        chk("mem_en", {31'b0, mem_en}, {31'b0, f});
        chk("mem_addr", mem_addr, m_pc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, q_pc.size() != 0});
        chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
        if (q_pc.size() != 0) begin
            chk("out_pc", out_pc, q_pc[0]);
            chk("out_instr", out_instr, q_ins[0]);
        end
    endtask

    task automatic tick();
        bit f, pop_now;
        @(posedge clk);
        f       = model_fetch();
        pop_now = (q_pc.size() != 0) && ready;
        if (branch) begin
            q_pc.delete();
            q_ins.delete();
            m_pc  = {ba[31:2], 2'b00};
            m_mis = (ba[1:0] != 2'b00);
        end else begin
            m_mis = 1'b0;
            if (pop_now) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (f) begin
                q_pc.push_back(m_pc);
                q_ins.push_back(rom[m_pc[11:2]]);
                m_pc = m_pc + 32'd4;
            end
        end
        if (!m_run && go) m_run = 1'b1;
        #1;
    endtask

    task automatic add_row(input logic g, s, b, input logic [31:0] a, input logic r,
                           input logic en, input logic [31:0] addr, input logic v,
                           input logic [31:0] pc, input logic mis);
        row_t x;
        x.g = g; x.s = s; x.b = b; x.a = a; x.r = r;
        x.e_en = en; x.e_addr = addr; x.e_v = v; x.e_pc = pc; x.e_mis = mis;
        rows.push_back(x);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_out_pc"}, out_pc, 32'd0);
        chk({tag, "_out_instr"}, out_instr, 32'd0);
        chk({tag, "_misalign"}, {31'b0, misalign}, 32'd0);
        chk({tag, "_wrap_addr"}, w_addr, WRAP_PC);
    endtask

    initial begin
        logic [31:0] wexp [3];
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;

        // Power-on reset.
        #1 reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Wrap-around of the PC in the second instance; the main DUT stays idle.
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
        w_go = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_idle_en", {31'b0, w_en}, 32'd0);
        tick();
        w_go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            chk("wrap_en", {31'b0, w_en}, 32'd1);
            chk("wrap_addr", w_addr, wexp[i]);
            if (i >= 1) begin
                chk("wrap_valid", {31'b0, w_valid}, 32'd1);
                chk("wrap_out_pc", w_opc, wexp[i-1]);
            end
            tick();
        end

        // Directed table: start, back-pressure fill, release, branch flush, misaligned+stalled branch.
        add_row(1'b1, 1'b0, 1'b0, 32'h00, 1'b0,  1'b0, 32'h00, 1'b0, 32'h00, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 32'h00, 1'b0,  1'b1, 32'h00, 1'b0, 32'h00, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 32'h00, 1'b0,  1'b1, 32'h04, 1'b1, 32'h00, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 32'h00, 1'b0,  1'b0, 32'h08, 1'b1, 32'h00, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 32'h00, 1'b0,  1'b0, 32'h08, 1'b1, 32'h00, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 32'h00, 1'b1,  1'b1, 32'h08, 1'b1, 32'h00, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 32'h00, 1'b0,  1'b0, 32'h0C, 1'b1, 32'h04, 1'b0);
        add_row(1'b0, 1'b0, 1'b1, 32'h40, 1'b0,  1'b0, 32'h0C, 1'b1, 32'h04, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 32'h00, 1'b1,  1'b1, 32'h40, 1'b0, 32'h00, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 32'h00, 1'b1,  1'b1, 32'h44, 1'b1, 32'h40, 1'b0);
        add_row(1'b0, 1'b1, 1'b1, 32'h42, 1'b1,  1'b0, 32'h48, 1'b1, 32'h44, 1'b0);
        add_row(1'b0, 1'b1, 1'b0, 32'h00, 1'b1,  1'b0, 32'h40, 1'b0, 32'h00, 1'b1);
        add_row(1'b0, 1'b0, 1'b0, 32'h00, 1'b1,  1'b1, 32'h40, 1'b0, 32'h00, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 32'h00, 1'b1,  1'b1, 32'h44, 1'b1, 32'h40, 1'b0);
        foreach (rows[i]) begin
            apply(rows[i].g, rows[i].s, rows[i].b, rows[i].a, rows[i].r);
            chk($sformatf("row%0d_en", i), {31'b0, mem_en}, {31'b0, rows[i].e_en});
            chk($sformatf("row%0d_addr", i), mem_addr, rows[i].e_addr);
            chk($sformatf("row%0d_valid", i), {31'b0, out_valid}, {31'b0, rows[i].e_v});
            chk($sformatf("row%0d_mis", i), {31'b0, misalign}, {31'b0, rows[i].e_mis});
            if (rows[i].e_v) chk($sformatf("row%0d_pc", i), out_pc, rows[i].e_pc);
            tick();
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            apply(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 9) == 0), a, 1'($urandom_range(0, 9) < 7));
            tick();
        end

        // Mid-stream reset between edges: outputs must clear before the next edge.
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            apply(1'(i == 0), 1'b0, 1'b0, 32'h0, 1'b1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
